// File: rtl/axi_id_alloc_pkg.sv
// Shared types for the AXI ID allocator/arbiter: arbiter FSM states and index-width helper.
// No logic or state of its own.
package axi_id_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit, even for a degenerate count of 1.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_id_alloc_arb_rr.sv
// rr_arb_tree_lite: round-robin pick of the first set request at or after ptr_i, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arb_tree_lite #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    int unsigned idx;

    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_o && req_i[IDX_W'(idx)]) begin
                any_o     = 1'b1;
                gnt_idx_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_id_alloc_arb.sv
// Round-robin arbiter + downstream ID allocator (lowest free slot); translates released IDs back.
// Request->out_valid_o is combinational; a stalled grant is locked until out_ready_i; no grant when full.
// Optional registered occupancy counter: define AXI_ID_ALLOC_ARB_OCC_EN.
module axi_id_alloc_arb
    import axi_id_alloc_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ID_WIDTH_IN  = 4,
    parameter int unsigned ID_WIDTH_OUT = 4,
    parameter int unsigned TABLE_SIZE   = 4,
    localparam int unsigned REQ_W       = idx_w(NUM_REQ),
    localparam int unsigned SLOT_W      = idx_w(TABLE_SIZE)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0][ID_WIDTH_IN-1:0]   req_id_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic                                  out_valid_o,
    output logic [ID_WIDTH_OUT-1:0]               out_id_o,
    output logic [REQ_W-1:0]                      out_req_o,
    input  logic                                  out_ready_i,
    input  logic                                  rel_valid_i,
    input  logic [ID_WIDTH_OUT-1:0]               rel_id_i,
    output logic [REQ_W-1:0]                      rel_req_o,
    output logic [ID_WIDTH_IN-1:0]                rel_orig_id_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [SLOT_W:0]                       occupancy_o
);

    typedef struct packed {
        logic                   vld;
        logic [REQ_W-1:0]       req;
        logic [ID_WIDTH_IN-1:0] orig;
    } slot_t;

    slot_t             tbl_q [TABLE_SIZE];
    logic [TABLE_SIZE-1:0] vld_vec;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W-1:0] rel_idx;
    logic              rel_ok;

    arb_state_e        state_q;
    logic [REQ_W-1:0]  grant_q;
    logic [SLOT_W-1:0] slot_q;
    logic [REQ_W-1:0]  rr_ptr_q;

    logic [REQ_W-1:0]  arb_idx;
    logic              arb_any;
    logic              out_vld;
    logic [REQ_W-1:0]  out_req;
    logic [SLOT_W-1:0] out_slot;
    logic              fire;

    always_comb begin
        vld_vec = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            vld_vec[i] = tbl_q[i].vld;
        end
    end

    assign full_o  = &vld_vec;
    assign empty_o = ~|vld_vec;

    // Descending scan so the last hit is the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (!vld_vec[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
    end

    rr_arb_tree_lite #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_W)
    ) u_rr (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        out_vld  = 1'b0;
        out_req  = '0;
        out_slot = '0;
        if (state_q == LOCKED) begin
            out_vld  = 1'b1;
            out_req  = grant_q;
            out_slot = slot_q;
        end else if (arb_any && !full_o) begin
            out_vld  = 1'b1;
            out_req  = arb_idx;
            out_slot = free_idx;
        end
    end

    assign fire        = out_vld & out_ready_i;
    assign out_valid_o = out_vld;
    assign out_req_o   = out_req;
    assign out_id_o    = ID_WIDTH_OUT'(out_slot);
    assign req_ready_o = fire ? (NUM_REQ'(1) << out_req) : '0;

    assign rel_idx       = rel_id_i[SLOT_W-1:0];
    assign rel_ok        = rel_valid_i & tbl_q[rel_idx].vld;
    assign rel_req_o     = tbl_q[rel_idx].req;
    assign rel_orig_id_o = tbl_q[rel_idx].orig;

    if (ID_WIDTH_OUT > SLOT_W) begin : g_rel_hi
        logic unused_rel_hi;
        assign unused_rel_hi = ^rel_id_i[ID_WIDTH_OUT-1:SLOT_W];
    end

    // Allocated slot was free pre-edge, so it never collides with a valid release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                if (fire && out_slot == SLOT_W'(i)) begin
                    tbl_q[i] <= '{vld: 1'b1, req: out_req, orig: req_id_i[out_req]};
                end else if (rel_ok && rel_idx == SLOT_W'(i)) begin
                    tbl_q[i].vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            slot_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_vld && !out_ready_i) begin
                        state_q <= LOCKED;
                        grant_q <= out_req;
                        slot_q  <= out_slot;
                    end
                end
                LOCKED: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (fire) begin
                rr_ptr_q <= (out_req == REQ_W'(NUM_REQ - 1)) ? '0 : out_req + 1'b1;
            end
        end
    end

`ifdef AXI_ID_ALLOC_ARB_OCC_EN
    logic [SLOT_W:0] occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else if (fire && !rel_ok) begin
            occ_q <= occ_q + 1'b1;
        end else if (rel_ok && !fire) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    assign occupancy_o = occ_q;

    a_occ_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(occ_q) == $countones(vld_vec))
        else $error("occupancy counter %0d disagrees with table", occ_q);
`else
    assign occupancy_o = '0;
`endif

    a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == LOCKED) |-> req_valid_i[grant_q])
        else $error("requester %0d dropped valid while its grant was locked", grant_q);

    a_rel_valid_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rel_valid_i |-> tbl_q[rel_idx].vld)
        else $warning("release of idle slot %0d ignored", rel_idx);

endmodule
